// File: rtl/awgn_channel_noise_if.sv
// rtl/awgn_channel_noise_if.sv - stream/register bundle for the AWGN noise generator and channel adder
// Purpose: groups the enable, random-word input, signal in/out, noise and histogram signals.
// Ports (by modport):
//   master : drives en, rand_in/rand_valid, sig_in/sig_in_valid, hist_addr/hist_clr;
//            observes sig_out/sig_out_valid, noise_out/noise_out_valid, noise_underflow, hist_data
//   slave  : the mirror image, used by awgn_channel_noise
interface awgn_channel_noise_if #(
    parameter int LEVELS            = 7,
    parameter int RAND_WIDTH        = 64,
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int HIST_WIDTH        = 16
);
    logic                                en;
    logic        [RAND_WIDTH-1:0]        rand_in;
    logic                                rand_valid;
    logic signed [SIGNAL_RESOLUTION-1:0] sig_in;
    logic                                sig_in_valid;
    logic signed [SIGNAL_RESOLUTION-1:0] sig_out;
    logic                                sig_out_valid;
    logic signed [LEVELS:0]              noise_out;
    logic                                noise_out_valid;
    logic                                noise_underflow;
    logic        [LEVELS-1:0]            hist_addr;
    logic                                hist_clr;
    logic        [HIST_WIDTH-1:0]        hist_data;

    modport master (
        output en, rand_in, rand_valid, sig_in, sig_in_valid, hist_addr, hist_clr,
        input  sig_out, sig_out_valid, noise_out, noise_out_valid, noise_underflow, hist_data
    );

    modport slave (
        input  en, rand_in, rand_valid, sig_in, sig_in_valid, hist_addr, hist_clr,
        output sig_out, sig_out_valid, noise_out, noise_out_valid, noise_underflow, hist_data
    );
endinterface

// File: rtl/awgn_channel_noise.sv
// rtl/awgn_channel_noise.sv - inverse-CDF Gaussian noise generator with saturating channel adder
// Purpose: a LEVELS-stage pipelined binary search maps each uniform random word to a noise index
//   over a monotone cumulative-probability table; the centred noise sample is held and added, with
//   saturation, to the next accepted signal sample. One sample per cycle.
// Ports:
//   clk   - clock
//   rstn  - asynchronous active-low reset
//   bus   - awgn_channel_noise_if.slave (en, rand_in/rand_valid, sig_in/sig_in_valid, sig_out/sig_out_valid,
//           noise_out/noise_out_valid, noise_underflow, hist_addr/hist_clr/hist_data)
// Table: PROB_TABLE packs 2**LEVELS entries of RAND_WIDTH bits, entry i at bits [i*RAND_WIDTH +: RAND_WIDTH].
//   An all-zero PROB_TABLE selects a built-in linear ramp.
// Optional feature: define NOISE_HIST_EN to build the per-index histogram counters.
module awgn_channel_noise #(
    parameter int LEVELS            = 7,
    parameter int RAND_WIDTH        = 64,
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int HIST_WIDTH        = 16,
    parameter logic [(2**LEVELS)*RAND_WIDTH-1:0] PROB_TABLE = '0
) (
    input  logic               clk,
    input  logic               rstn,
    awgn_channel_noise_if.slave bus
);
    localparam int DEPTH  = 2**LEVELS;
    localparam int SR     = SIGNAL_RESOLUTION;
    localparam int OFFSET = 2**(LEVELS-1) - 1;

    if (LEVELS >= SIGNAL_RESOLUTION) begin : g_bad_levels
        $error("awgn_channel_noise: LEVELS must be smaller than SIGNAL_RESOLUTION");
    end

    function automatic logic [DEPTH*RAND_WIDTH-1:0] f_ramp();
        logic [DEPTH*RAND_WIDTH-1:0] t;
        t = '0;
        for (int i = 0; i < DEPTH; i++) begin
            t[i*RAND_WIDTH +: RAND_WIDTH] = RAND_WIDTH'(i + 1) << (RAND_WIDTH - LEVELS);
        end
        return t;
    endfunction

    localparam logic [DEPTH*RAND_WIDTH-1:0] TABLE = (PROB_TABLE == '0) ? f_ramp() : PROB_TABLE;

    // Search pipeline: stage s decides bit LEVELS-1-s of the index, MSB first.
    for (genvar s = 0; s < LEVELS; s++) begin : g_stage
        localparam int K = LEVELS - 1 - s;

        logic [RAND_WIDTH-1:0] w_rand;
        logic [LEVELS-1:0]     w_prefix;
        logic                  w_vld;
        logic [LEVELS-1:0]     w_cand;
        logic [RAND_WIDTH-1:0] w_thresh;

        logic [RAND_WIDTH-1:0] r_rand;
        logic [LEVELS-1:0]     r_prefix;
        logic                  r_vld;

        if (s == 0) begin : g_first
            assign w_rand   = bus.rand_in;
            assign w_prefix = '0;
            assign w_vld    = bus.rand_valid;
        end else begin : g_next
            assign w_rand   = g_stage[s-1].r_rand;
            assign w_prefix = g_stage[s-1].r_prefix;
            assign w_vld    = g_stage[s-1].r_vld;
        end

        // cand is never 0, so cand-1 stays inside 0..DEPTH-2; the last table entry is never read.
        assign w_cand   = w_prefix | LEVELS'(1 << K);
        assign w_thresh = TABLE[(int'(w_cand) - 1)*RAND_WIDTH +: RAND_WIDTH];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_rand   <= '0;
                r_prefix <= '0;
                r_vld    <= 1'b0;
            end else if (bus.en) begin
                r_rand   <= w_rand;
                r_prefix <= (w_rand >= w_thresh) ? w_cand : w_prefix;
                r_vld    <= w_vld;
            end
        end
    end

    logic [LEVELS-1:0]        w_sel;
    logic                     w_sel_vld;
    logic signed [LEVELS:0]   w_noise_new;
    logic signed [LEVELS:0]   w_noise_used;
    logic signed [SR:0]       w_noise_ext;
    logic signed [SR:0]       w_sig_ext;
    logic signed [SR:0]       w_sum;
    logic signed [SR-1:0]     w_sat;

    logic signed [LEVELS:0]   r_noise;
    logic                     r_noise_valid;
    logic                     r_noise_avail;
    logic signed [SR-1:0]     r_sig_out;
    logic                     r_sig_valid;
    logic                     r_underflow;

    assign w_sel       = g_stage[LEVELS-1].r_prefix;
    assign w_sel_vld   = g_stage[LEVELS-1].r_vld;
    assign w_noise_new = $signed({1'b0, w_sel}) - $signed((LEVELS+1)'(OFFSET));

    // With no held sample the signal passes through unchanged.
    assign w_noise_used = r_noise_avail ? r_noise : '0;
    assign w_noise_ext  = {{(SR-LEVELS){w_noise_used[LEVELS]}}, w_noise_used};
    assign w_sig_ext    = {bus.sig_in[SR-1], bus.sig_in};
    assign w_sum        = w_sig_ext + w_noise_ext;

    always_comb begin
        w_sat = w_sum[SR-1:0];
        if (w_sum[SR] != w_sum[SR-1]) begin
            w_sat = w_sum[SR] ? {1'b1, {(SR-1){1'b0}}} : {1'b0, {(SR-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_noise       <= '0;
            r_noise_valid <= 1'b0;
            r_noise_avail <= 1'b0;
            r_sig_out     <= '0;
            r_sig_valid   <= 1'b0;
            r_underflow   <= 1'b0;
        end else if (!bus.en) begin
            // Data outputs hold; valid pulses drop so a frozen pulse is never seen twice.
            r_noise_valid <= 1'b0;
            r_sig_valid   <= 1'b0;
        end else begin
            r_noise_valid <= w_sel_vld;
            r_sig_valid   <= bus.sig_in_valid;
            if (bus.sig_in_valid) begin
                r_sig_out <= w_sat;
                if (!r_noise_avail) begin
                    r_underflow <= 1'b1;
                end
            end
            // A sample landing on the same edge as a consumption is the one left held.
            if (w_sel_vld) begin
                r_noise       <= w_noise_new;
                r_noise_avail <= 1'b1;
            end else if (bus.sig_in_valid) begin
                r_noise_avail <= 1'b0;
            end
        end
    end

    assign bus.noise_out       = r_noise;
    assign bus.noise_out_valid = r_noise_valid;
    assign bus.sig_out         = r_sig_out;
    assign bus.sig_out_valid   = r_sig_valid;
    assign bus.noise_underflow = r_underflow;

    logic w_unused_rand;
    assign w_unused_rand = ^g_stage[LEVELS-1].r_rand;

`ifdef NOISE_HIST_EN
    logic [HIST_WIDTH-1:0] r_hist [DEPTH];
    logic [HIST_WIDTH-1:0] r_hist_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
            end
            r_hist_data <= '0;
        end else if (bus.en) begin
            if (bus.hist_clr) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_hist[i] <= '0;
                end
            end else if (w_sel_vld && (r_hist[w_sel] != '1)) begin
                r_hist[w_sel] <= r_hist[w_sel] + 1'b1;
            end
            r_hist_data <= r_hist[bus.hist_addr];
        end
    end

    assign bus.hist_data = r_hist_data;
`else
    logic w_unused_hist;
    assign w_unused_hist = ^{bus.hist_addr, bus.hist_clr};
    assign bus.hist_data = '0;
`endif
endmodule

// File: tb/tb_awgn_channel_noise.sv
// tb/tb_awgn_channel_noise.sv - scoreboard bench for awgn_channel_noise (LEVELS=3, SR=8, RAND_WIDTH=8)
module tb_awgn_channel_noise;
    localparam int L  = 3;
    localparam int RW = 8;
    localparam int SR = 8;
    localparam int HW = 16;
    localparam logic [8*RW-1:0] TB_TABLE =
        {8'd255, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic clk;
    logic rstn;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q_noise[$];
    exp_t q_sig[$];
    int   tbl[8] = '{10, 20, 30, 40, 50, 60, 70, 255};

    awgn_channel_noise_if #(
        .LEVELS(L), .RAND_WIDTH(RW), .SIGNAL_RESOLUTION(SR), .HIST_WIDTH(HW)
    ) bus ();

    awgn_channel_noise #(
        .LEVELS(L), .RAND_WIDTH(RW), .SIGNAL_RESOLUTION(SR), .HIST_WIDTH(HW), .PROB_TABLE(TB_TABLE)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int golden(input int r);
        int s = 0;
        for (int i = 0; i < 7; i++) begin
            if (r >= tbl[i]) s++;
        end
        return s - 3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One cycle of stimulus; expectations are queued with the edge at which they must appear.
    task automatic step(input bit rv, input int r, input int en_exp,
                        input bit sv, input int s, input int es, input int lat = 3);
        bus.rand_valid   = rv;
        bus.rand_in      = r[7:0];
        bus.sig_in_valid = sv;
        bus.sig_in       = s[7:0];
        tick();
        if (rv) q_noise.push_back('{en_exp, cyc + lat - 1});
        if (sv) q_sig.push_back('{es, cyc});
        bus.rand_valid   = 1'b0;
        bus.sig_in_valid = 1'b0;
    endtask

    // Monitor: pops and compares on every output pulse.
    always @(negedge clk) begin
        exp_t e;
        if (bus.noise_out_valid) begin
            if (q_noise.size() == 0) begin
                check("noise_unexpected_pulse", 1, 0);
            end else begin
                e = q_noise.pop_front();
                check("noise_value", int'($signed(bus.noise_out)), e.val);
                check("noise_latency", cyc, e.cyc + 1);
            end
        end
        if (bus.sig_out_valid) begin
            if (q_sig.size() == 0) begin
                check("sig_unexpected_pulse", 1, 0);
            end else begin
                e = q_sig.pop_front();
                check("sig_value", int'($signed(bus.sig_out)), e.val);
                check("sig_latency", cyc, e.cyc);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_sig_out"}, int'(bus.sig_out), 0);
        check({tag, "_sig_out_valid"}, int'(bus.sig_out_valid), 0);
        check({tag, "_noise_out"}, int'(bus.noise_out), 0);
        check({tag, "_noise_out_valid"}, int'(bus.noise_out_valid), 0);
        check({tag, "_underflow"}, int'(bus.noise_underflow), 0);
        check({tag, "_hist_data"}, int'(bus.hist_data), 0);
    endtask

    initial begin
        int r;
        rstn             = 1'b0;
        bus.en           = 1'b1;
        bus.rand_in      = '0;
        bus.rand_valid   = 1'b0;
        bus.sig_in       = '0;
        bus.sig_in_valid = 1'b0;
        bus.hist_addr    = '0;
        bus.hist_clr     = 1'b0;
        idle(3);
        check_all_zero("reset");
        rstn = 1'b1;
        idle(2);

        // Signal before any noise: passthrough and sticky underflow.
        step(0, 0, 0, 1, 5, 5);
        check("underflow_set", int'(bus.noise_underflow), 1);

        // Directed search vectors.
        step(1, 0, -3, 0, 0, 0);
        step(1, 35, 0, 0, 0, 0);
        step(1, 70, 4, 0, 0, 0);
        step(1, 255, 4, 0, 0, 0);
        idle(4);

        // Saturation both ways.
        step(0, 0, 0, 1, 126, 127);
        idle(1);
        step(1, 0, -3, 0, 0, 0);
        idle(3);
        step(0, 0, 0, 1, -127, -128);
        check("underflow_sticky", int'(bus.noise_underflow), 1);

        // Same-edge consume/arrive: +4 is consumed, 0 stays held.
        step(1, 70, 4, 0, 0, 0);
        step(1, 35, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 1, 10, 14);
        step(0, 0, 0, 1, 20, 20);

        // Continuous random stream against the counting model.
        for (int i = 0; i < 20; i++) begin
            r = int'($urandom_range(0, 255));
            step(1, r, golden(r), 0, 0, 0);
        end
        idle(4);

        // Reset with three samples in flight.
        bus.rand_valid = 1'b1;
        bus.rand_in    = 8'd60;
        idle(3);
        bus.rand_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("midreset");
        idle(2);
        rstn = 1'b1;
        idle(4);
        check_all_zero("postreset");
        step(1, 0, -3, 0, 0, 0);
        idle(3);
        step(0, 0, 0, 1, 50, 47);
        check("underflow_cleared", int'(bus.noise_underflow), 0);

        // Freeze with one sample in stage 0 while inputs toggle.
        step(1, 255, 4, 0, 0, 0, 8);
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.rand_valid   = 1'b1;
            bus.rand_in      = 8'd0;
            bus.sig_in_valid = 1'b1;
            bus.sig_in       = 8'd100;
            tick();
            check("freeze_noise_out", int'($signed(bus.noise_out)), -3);
            check("freeze_sig_out", int'($signed(bus.sig_out)), 47);
            check("freeze_underflow", int'(bus.noise_underflow), 0);
        end
        bus.rand_valid   = 1'b0;
        bus.sig_in_valid = 1'b0;
        bus.en           = 1'b1;
        idle(3);
        step(0, 0, 0, 1, 0, 4);
        idle(1);

`ifdef NOISE_HIST_EN
        bus.hist_clr = 1'b1;
        tick();
        bus.hist_clr = 1'b0;
        for (int i = 0; i < 100; i++) step(1, 35, 0, 0, 0, 0);
        idle(4);
        bus.hist_addr = 3'd3;
        tick();
        check("hist_count_3", int'(bus.hist_data), 100);
        bus.hist_addr = 3'd7;
        tick();
        check("hist_count_7", int'(bus.hist_data), 0);
        bus.hist_addr = 3'd3;
        bus.hist_clr  = 1'b1;
        tick();
        bus.hist_clr = 1'b0;
        tick();
        check("hist_cleared", int'(bus.hist_data), 0);
`else
        for (int a = 0; a < 8; a++) begin
            bus.hist_addr = a[2:0];
            bus.hist_clr  = a[0];
            tick();
            check("hist_tied_zero", int'(bus.hist_data), 0);
        end
        bus.hist_clr = 1'b0;
`endif

        check("noise_queue_drained", q_noise.size(), 0);
        check("sig_queue_drained", q_sig.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
